// File: rtl/sys_defs.sv
// Shared system definitions: data widths, memory bus commands and the
// instruction-cache state and tag types.
package sys_defs;

   localparam int XLEN         = 32;
   localparam int ICACHE_LINES = 32;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } MEM_COMMAND;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } ICACHE_STATE;

   // Tag field is sized for the smallest legal cache, so any NUM_LINES fits.
   typedef struct packed {
      logic            valid;
      logic [XLEN-4:0] tag;
   } ICACHE_TAG;

   function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/icache_data_array.sv
// Line storage for the instruction cache: one synchronous write port and a
// combinational read port. Contents are not reset.
module icache_data_array
   import sys_defs::*;
#(
   parameter int NUM_LINES = ICACHE_LINES,
   localparam int IDX_BITS = $clog2(NUM_LINES)
) (
   input  logic                clock,
   input  logic                we,
   input  logic [IDX_BITS-1:0] waddr,
   input  logic [63:0]         wdata,
   input  logic [IDX_BITS-1:0] raddr,
   output logic [63:0]         rdata
);

   logic [63:0] mem [NUM_LINES];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, one
// outstanding tagged line load per miss, fill tracked by tag match.
module icache_dm
   import sys_defs::*;
#(
   parameter int NUM_LINES = ICACHE_LINES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [XLEN-1:0]  proc2Icache_addr,
   output logic [63:0]      Icache2proc_data,
   output logic             Icache2proc_data_valid,
   output MEM_COMMAND       proc2Imem_command,
   output logic [XLEN-1:0]  proc2Imem_addr,
   input  logic [3:0]       Imem2proc_response,
   input  logic [63:0]      Imem2proc_data,
   input  logic [3:0]       Imem2proc_tag
);

   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_W    = XLEN - 3;

   logic [IDX_BITS-1:0] cur_index;
   logic [TAG_W-1:0]    cur_tag;
   logic [XLEN-1:0]     cur_line;
   logic                hit;

   ICACHE_TAG           tag_mem [NUM_LINES];

   ICACHE_STATE         state, state_next;
   logic [3:0]          pending_tag, pending_tag_next;
   logic [IDX_BITS-1:0] miss_index;
   logic [TAG_W-1:0]    miss_tag;
   logic [XLEN-1:0]     miss_line;
   logic                latch_miss;
   logic                fill;
   MEM_COMMAND          command;

   assign cur_index = proc2Icache_addr[3+IDX_BITS-1:3];
   assign cur_tag   = TAG_W'(proc2Icache_addr >> (3 + IDX_BITS));
   assign cur_line  = line_addr(proc2Icache_addr);

   assign hit = tag_mem[cur_index].valid && (tag_mem[cur_index].tag == cur_tag);

   assign Icache2proc_data_valid = hit;
   assign proc2Imem_command      = command;
   assign proc2Imem_addr         = miss_line;

   always_comb begin
      state_next       = state;
      pending_tag_next = pending_tag;
      latch_miss       = 1'b0;
      fill             = 1'b0;
      command          = BUS_NONE;
      case (state)
         IDLE: begin
            if (!hit) begin
               latch_miss = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            command = BUS_LOAD;
            if (Imem2proc_response != 4'd0) begin
               pending_tag_next = Imem2proc_response;
               state_next       = WAIT;
            end else if (cur_line != miss_line) begin
               // Fetch moved on before the bus took the request: chase the new line.
               if (hit) begin
                  state_next = IDLE;
               end else begin
                  latch_miss = 1'b1;
               end
            end
         end
         WAIT: begin
            if ((Imem2proc_tag != 4'd0) && (Imem2proc_tag == pending_tag)) begin
               fill       = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pending_tag <= 4'd0;
         miss_index  <= '0;
         miss_tag    <= '0;
         miss_line   <= '0;
      end else begin
         state       <= state_next;
         pending_tag <= pending_tag_next;
         if (latch_miss) begin
            miss_index <= cur_index;
            miss_tag   <= cur_tag;
            miss_line  <= cur_line;
         end
      end
   end

   // Fill takes its tag from the latched miss, never from the live fetch address.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LINES; gi++) begin : g_tag
         always_ff @(posedge clock) begin
            if (reset) begin
               tag_mem[gi] <= '0;
            end else if (fill && (miss_index == IDX_BITS'(gi))) begin
               tag_mem[gi] <= '{valid: 1'b1, tag: miss_tag};
            end
         end
      end
   endgenerate

   icache_data_array #(
      .NUM_LINES (NUM_LINES)
   ) u_data (
      .clock (clock),
      .we    (fill),
      .waddr (miss_index),
      .wdata (Imem2proc_data),
      .raddr (cur_index),
      .rdata (Icache2proc_data)
   );

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit, retry, foreign tag,
// address change during a fill, conflict eviction and reset mid-miss.
module tb_icache_dm;
   import sys_defs::*;

   logic             clock;
   logic             reset;
   logic [XLEN-1:0]  proc2Icache_addr;
   logic [63:0]      Icache2proc_data;
   logic             Icache2proc_data_valid;
   MEM_COMMAND       proc2Imem_command;
   logic [XLEN-1:0]  proc2Imem_addr;
   logic [3:0]       Imem2proc_response;
   logic [63:0]      Imem2proc_data;
   logic [3:0]       Imem2proc_tag;

   int assertions = 0;
   int failures   = 0;

   localparam logic [63:0] NONE = 64'(BUS_NONE);
   localparam logic [63:0] LOAD = 64'(BUS_LOAD);

   icache_dm #(.NUM_LINES(32)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .proc2Icache_addr       (proc2Icache_addr),
      .Icache2proc_data       (Icache2proc_data),
      .Icache2proc_data_valid (Icache2proc_data_valid),
      .proc2Imem_command      (proc2Imem_command),
      .proc2Imem_addr         (proc2Imem_addr),
      .Imem2proc_response     (Imem2proc_response),
      .Imem2proc_data         (Imem2proc_data),
      .Imem2proc_tag          (Imem2proc_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      assertions++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   // One cycle: drive inputs after the falling edge, settle, then let checks sample.
   task automatic cyc(input logic [31:0] a, input logic [3:0] resp,
                      input logic [3:0] tag, input logic [63:0] data);
      @(negedge clock);
      proc2Icache_addr   = a;
      Imem2proc_response = resp;
      Imem2proc_tag      = tag;
      Imem2proc_data     = data;
      #1;
   endtask

   initial begin
      reset              = 1'b1;
      proc2Icache_addr   = '0;
      Imem2proc_response = '0;
      Imem2proc_tag      = '0;
      Imem2proc_data     = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      check("reset_valid", 64'(Icache2proc_data_valid), 64'd0);
      check("reset_cmd",   64'(proc2Imem_command), NONE);
      check("reset_maddr", 64'(proc2Imem_addr), 64'd0);

      // Cold miss on 0x0: accept with tag 3 on cycle 2, return on cycle 6.
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("cold_c0_valid", 64'(Icache2proc_data_valid), 64'd0);
      check("cold_c0_cmd",   64'(proc2Imem_command), NONE);
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      check("cold_c1_cmd",   64'(proc2Imem_command), LOAD);
      check("cold_c1_maddr", 64'(proc2Imem_addr), 64'h0);
      cyc(32'h0, 4'd3, 4'd0, 64'd0);
      check("cold_c2_cmd",   64'(proc2Imem_command), LOAD);
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      check("cold_c3_cmd",   64'(proc2Imem_command), NONE);
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      check("cold_c5_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h0, 4'd0, 4'd3, 64'h1111_2222_3333_4444);
      check("cold_fill_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      check("cold_c7_valid", 64'(Icache2proc_data_valid), 64'd1);
      check("cold_c7_data",  Icache2proc_data, 64'h1111_2222_3333_4444);

      // Hit on the same line with different low bits.
      cyc(32'h4, 4'd0, 4'd0, 64'd0);
      check("hit_valid", 64'(Icache2proc_data_valid), 64'd1);
      check("hit_data",  Icache2proc_data, 64'h1111_2222_3333_4444);
      check("hit_cmd",   64'(proc2Imem_command), NONE);
      cyc(32'h4, 4'd0, 4'd0, 64'd0);
      check("hit_next_cmd", 64'(proc2Imem_command), NONE);

      // Retry: 0x208 (index 1) refused four times, then accepted with tag 5.
      cyc(32'h208, 4'd0, 4'd0, 64'd0);
      check("retry_c0_valid", 64'(Icache2proc_data_valid), 64'd0);
      for (int i = 1; i <= 5; i++) begin
         cyc(32'h208, (i == 5) ? 4'd5 : 4'd0, 4'd0, 64'd0);
         check($sformatf("retry_c%0d_cmd", i), 64'(proc2Imem_command), LOAD);
         check($sformatf("retry_c%0d_maddr", i), 64'(proc2Imem_addr), 64'h208);
      end
      // Foreign tag 2 must not fill; tag 5 then does.
      cyc(32'h208, 4'd0, 4'd2, 64'hDEAD_DEAD_DEAD_DEAD);
      check("retry_c6_cmd", 64'(proc2Imem_command), NONE);
      cyc(32'h208, 4'd0, 4'd0, 64'd0);
      check("foreign_valid", 64'(Icache2proc_data_valid), 64'd0);
      check("foreign_cmd",   64'(proc2Imem_command), NONE);
      cyc(32'h208, 4'd0, 4'd5, 64'hAAAA_BBBB_CCCC_DDDD);
      check("foreign_fillcyc_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h208, 4'd0, 4'd0, 64'd0);
      check("own_tag_valid", 64'(Icache2proc_data_valid), 64'd1);
      check("own_tag_data",  Icache2proc_data, 64'hAAAA_BBBB_CCCC_DDDD);
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      check("line0_kept", 64'(Icache2proc_data_valid), 64'd1);

      // Miss on 0x100 accepted with tag 7, fetch jumps to 0x800 while waiting.
      cyc(32'h100, 4'd0, 4'd0, 64'd0);
      check("chg_c0_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h100, 4'd7, 4'd0, 64'd0);
      check("chg_c1_cmd", 64'(proc2Imem_command), LOAD);
      cyc(32'h800, 4'd0, 4'd0, 64'd0);
      check("chg_c2_cmd", 64'(proc2Imem_command), NONE);
      cyc(32'h800, 4'd0, 4'd0, 64'd0);
      check("chg_c3_cmd", 64'(proc2Imem_command), NONE);
      cyc(32'h800, 4'd0, 4'd7, 64'h0100_0100_0100_0100);
      check("chg_c4_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h100, 4'd0, 4'd0, 64'd0);
      check("chg_0x100_valid", 64'(Icache2proc_data_valid), 64'd1);
      check("chg_0x100_data",  Icache2proc_data, 64'h0100_0100_0100_0100);
      // 0x000 shares index 0 and was evicted; its miss then chases 0x800.
      cyc(32'h0, 4'd0, 4'd0, 64'd0);
      check("evict_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h800, 4'd0, 4'd0, 64'd0);
      check("relatch_c0_cmd",   64'(proc2Imem_command), LOAD);
      check("relatch_c0_maddr", 64'(proc2Imem_addr), 64'h0);
      cyc(32'h800, 4'd9, 4'd0, 64'd0);
      check("relatch_c1_cmd",   64'(proc2Imem_command), LOAD);
      check("relatch_c1_maddr", 64'(proc2Imem_addr), 64'h800);

      // Reset while waiting on tag 9; the late return must be dropped.
      @(negedge clock);
      reset              = 1'b1;
      Imem2proc_response = 4'd0;
      #1;
      check("rstwait_cmd", 64'(proc2Imem_command), NONE);
      @(negedge clock);
      reset = 1'b0;
      Imem2proc_tag  = 4'd9;
      Imem2proc_data = 64'h9999_9999_9999_9999;
      #1;
      check("late_cmd",   64'(proc2Imem_command), NONE);
      check("late_valid", 64'(Icache2proc_data_valid), 64'd0);
      check("late_maddr", 64'(proc2Imem_addr), 64'h0);
      cyc(32'h800, 4'd0, 4'd0, 64'd0);
      check("late_next_valid", 64'(Icache2proc_data_valid), 64'd0);
      cyc(32'h208, 4'd0, 4'd0, 64'd0);
      check("rst_cleared_208", 64'(Icache2proc_data_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory bus. Serves 64-bit memory lines to fetch on a hit in the same cycle the address is presented. Handles misses with one outstanding tagged memory load and fills the line when the matching tag returns. Fetch holds its address and waits on `Icache2proc_data_valid`, so the cache never needs a stall output.

## Interface
- `NUM_LINES`, default 32: number of 8-byte lines; must be a power of two.
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `proc2Icache_addr`  in  XLEN  fetch address; bits [2:0] are ignored
- `Icache2proc_data`  out  64  line data for the current address
- `Icache2proc_data_valid`  out  1  current address hits
- `proc2Imem_command`  out  MEM_COMMAND  BUS_NONE or BUS_LOAD
- `proc2Imem_addr`  out  XLEN  line address of the miss, with bits [2:0] = 0
- `Imem2proc_response`  in  4  nonzero means request accepted; the value is the transaction tag
- `Imem2proc_data`  in  64  returned line
- `Imem2proc_tag`  in  4  tag of `Imem2proc_data`; 0 means no data this cycle

## Operation
- Address split:
  - `IDX_BITS = $clog2(NUM_LINES)`
  - index = `addr[3+IDX_BITS-1:3]`
  - tag = `addr[XLEN-1:3+IDX_BITS]`
- Per-line state: a valid bit plus a stored tag, and 64 data bits.
- Hit = `valid[index] && tag_array[index] == tag`. Hit is combinational from registered arrays.
- `Icache2proc_data` = `data[index]` at all times. It is only meaningful when valid is high.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on a miss, latch miss_index, miss_tag and line address, then go to REQ. On a hit, stay in IDLE.
  - REQ: drive BUS_LOAD with the latched address.
    - If the response is nonzero, store it as `pending_tag` and go to WAIT.
    - If the response is 0, retry next cycle.
    - If the fetch address changed to another line and the request was not accepted, re-latch the new line. If the new address hits, return to IDLE.
  - WAIT: drive BUS_NONE. When `Imem2proc_tag == pending_tag` and `Imem2proc_tag != 0`:
    - write the data to `miss_index`;
    - set valid and the tag from `miss_tag`, never from the current address;
    - go to IDLE.
- An address change during WAIT is ignored until the fill completes. The fill for the old line always completes; the new miss starts from IDLE.
- Returns with non-matching tags are ignored. They belong to other requesters.
- Only one outstanding miss exists at a time. Data is never forwarded from the bus to fetch on the fill cycle.

## Timing
- Reset values:
  - all valid bits = 0
  - state = IDLE, `pending_tag` = 0
  - `proc2Imem_command` = BUS_NONE, `proc2Imem_addr` = 0
  - `Icache2proc_data_valid` = 0
  - `Icache2proc_data` is don't-care; the data array is not reset.
- Hit latency is 0 cycles: combinational from address to valid/data.
- Miss-to-hit latency:
  - Cycle 0: miss detected; the FSM registers REQ.
  - Cycle 1: BUS_LOAD is driven.
  - Cycle N: the tag matches and the write occurs at the clock edge.
  - Cycle N+1: valid is high.
- BUS_LOAD is asserted only in REQ. It stays asserted on consecutive cycles until a nonzero response.
- Reset during REQ or WAIT returns to IDLE and clears `pending_tag`. A late memory return is then discarded: the tag compare fails because the FSM is in IDLE.
- A fill into an index that fetch is reading updates the outputs on the following cycle.

## Structure
- The shared sys_defs package holds:
  - `XLEN`
  - the `MEM_COMMAND` enum (BUS_NONE, BUS_LOAD, BUS_STORE)
  - `ICACHE_LINES`, default 32
  - an `ICACHE_STATE` enum (IDLE, REQ, WAIT)
  - an `ICACHE_TAG` packed struct {valid, tag}
- One sub-module, `icache_data_array`: `NUM_LINES` x 64 registers with a single synchronous write port and a combinational read. It holds no reset logic.
- The tag/valid array and the FSM live in `icache_dm`.

## Test plan
- Cold miss:
  - Stimulus: reset, then addr 0x0000_0000. Memory accepts with response 3 after 2 cycles and returns tag 3 with data 0x1111_2222_3333_4444 at cycle 6.
  - Required: valid = 0 through the fill cycle; valid = 1 with that data the next cycle. BUS_LOAD is driven on exactly the cycles before acceptance.
- Hit after fill:
  - Stimulus: addr 0x0000_0004.
  - Required: same line, valid = 1 in the same cycle, with no bus command.
- Retry:
  - Stimulus: response = 0 for 4 cycles, then 5.
  - Required: BUS_LOAD with a constant address for 5 cycles, then BUS_NONE.
- Foreign tag:
  - Stimulus: pending_tag = 5; the bus returns tag 2 with data X.
  - Required: no fill, still in WAIT. The later tag 5 fills the line.
- Address change during WAIT:
  - Stimulus: the miss on 0x100 is outstanding; fetch switches to 0x800.
  - Required: 0x100 fills on index 0 with tag 0x100>>8, then a new BUS_LOAD for 0x800.
  - Required: a conflicting index (0x100 vs 0x000 with 32 lines) evicts the older line.
- Reset in WAIT:
  - Stimulus: assert reset, then the bus returns the old tag.
  - Required: no line becomes valid; command = BUS_NONE.
